// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, matrix geometry and phone-layout key map for the keypad scanner.
package keypad_pkg;
  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} cls_t;
  // nibble i holds the phone-layout label of raw code i (row*4+col)
  localparam logic [63:0] HEX_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] hex_map(input logic [3:0] code);
    return HEX_MAP[{code, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the debounced key event outputs.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_err;
  modport master (input row_in, output col_out, key_code, key_valid, key_held, key_err);
  modport slave (output row_in, input col_out, key_code, key_valid, key_held, key_err);
endinterface

// File: rtl/keypad_col_driver.sv
// keypad_col_driver: slot prescaler and one-hot-low column ring with per-slot sample strobe.
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int SLOT_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [KP_COLS-1:0] col_out,
  output logic [1:0]         col_idx,
  output logic               sample_en,
  output logic               frame_end
);
  localparam int SW = SLOT_CYC > 1 ? $clog2(SLOT_CYC) : 1;
  localparam logic [SW-1:0] LAST = SW'(SLOT_CYC - 1);
  logic [SW-1:0] slot;
  assign sample_en = slot == LAST;
  assign frame_end = sample_en && col_idx == 2'd3;
  assign col_out = ~(4'b0001 << col_idx);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      slot <= '0;
      col_idx <= '0;
    end else begin
      slot <= sample_en ? '0 : slot + 1'b1;
      col_idx <= col_idx + 2'(sample_en);
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with frame-based debounce; define KEYPAD_HEXMAP_EN
// to report keys through the phone-layout hex map instead of raw row*4+col codes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  keypad_scanner_if.master kp
);
  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
  localparam bit ONE_SHOT = DEBOUNCE_SCANS == 1;
  logic [KP_ROWS-1:0] s1, s2, hit;
  logic [3:0] col_out, code_acc, code_new, cand, cnt, key_code;
  logic [1:0] col_idx, row_idx, n_acc, n_new;
  logic [2:0] sum;
  logic sample_en, frame_end, cand_acc, cand_new, key_valid, key_held, key_err;
  cls_t cls;
  state_t state;
  function automatic logic [3:0] out_code(input logic [3:0] c);
`ifdef KEYPAD_HEXMAP_EN
    return hex_map(c);
`else
    return c;
`endif
  endfunction
  keypad_col_driver #(.SLOT_CYC(SLOT_CYC)) u_col (
    .clk(clk), .reset(reset), .col_out(col_out), .col_idx(col_idx),
    .sample_en(sample_en), .frame_end(frame_end)
  );
  assign kp.col_out = col_out;
  assign kp.key_code = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held = key_held;
  assign kp.key_err = key_err;
  // frame summary so far merged with the column being sampled now
  always_comb begin
    hit = ~s2;
    row_idx = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    sum = {1'b0, n_acc} + 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
    n_new = sum > 3'd1 ? 2'd2 : sum[1:0];
    code_new = |hit ? {row_idx, col_idx} : code_acc;
    cand_new = cand_acc | (col_idx == cand[1:0] && hit[cand[3:2]]);
    cls = n_new == 2'd0 ? NONE : n_new == 2'd1 ? SINGLE : MULTI;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
      n_acc <= '0;
      code_acc <= '0;
      cand_acc <= 1'b0;
      state <= SCAN;
      cand <= '0;
      cnt <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      key_err <= 1'b0;
    end else begin
      s1 <= kp.row_in;
      s2 <= s1;
      key_valid <= 1'b0;
      if (sample_en) begin
        n_acc <= frame_end ? '0 : n_new;
        code_acc <= frame_end ? '0 : code_new;
        cand_acc <= frame_end ? 1'b0 : cand_new;
      end
      if (frame_end) begin
        key_err <= cls == MULTI;
        case (state)
          SCAN:
            if (cls == SINGLE) begin
              cand <= code_new;
              if (ONE_SHOT) begin
                state <= HELD;
                key_code <= out_code(code_new);
                key_valid <= 1'b1;
                key_held <= 1'b1;
              end else begin
                state <= DEBOUNCE;
                cnt <= 4'd1;
              end
            end
          DEBOUNCE:
            if (cls == SINGLE && code_new == cand) begin
              if (cnt + 4'd1 == DB) begin
                state <= HELD;
                cnt <= '0;
                key_code <= out_code(cand);
                key_valid <= 1'b1;
                key_held <= 1'b1;
              end else cnt <= cnt + 4'd1;
            end else begin
              state <= SCAN;
              cnt <= '0;
            end
          HELD:
            if (!cand_new) begin
              state <= ONE_SHOT ? SCAN : RELEASE;
              cnt <= ONE_SHOT ? 4'd0 : 4'd1;
              key_held <= !ONE_SHOT;
            end
          RELEASE:
            if (cand_new) begin
              state <= HELD;
              cnt <= '0;
            end else if (cnt + 4'd1 == DB) begin
              state <= SCAN;
              cnt <= '0;
              key_held <= 1'b0;
            end else cnt <= cnt + 4'd1;
          default: state <= SCAN;
        endcase
      end
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad: drives one column low at a time and samples the row lines.
- Debounces over whole scan frames and emits a 4-bit key code with a one-cycle valid strobe, plus a held level.
- It is the input-side user interface: it feeds operands and commands into the ALU/display datapath, replacing raw switches and single buttons.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SCAN_HZ, 1000, column-slot rate in Hz; SLOT_CYC = CLK_HZ/SCAN_HZ (must be >= 4).
- DEBOUNCE_SCANS, 4, consecutive identical full-scan frames required to accept a press or a release (range 1..15).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- row_in, input, 4, keypad rows, active-low, externally pulled up.
- col_out, output, 4, keypad column drive, active-low, exactly one bit low at any time.
- key_code, output, 4, code of the last accepted key.
- key_valid, output, 1, one-cycle pulse when a new press is accepted.
- key_held, output, 1, high from acceptance until debounced release.
- key_err, output, 1, high for the frame following any scan frame that detected two or more pressed keys.

Behaviour:
- Reset (reset=0, async):
  - col_out=4'b1110; key_code=0; key_valid=0; key_held=0; key_err=0.
  - FSM=SCAN; slot/column/debounce counters=0; row synchronisers=4'b1111.
- row_in passes through a 2-flop synchroniser before use.
- Column slot:
  - Slot counter counts 0..SLOT_CYC-1.
  - Rows are sampled on the last cycle of the slot; col_out then rotates (col0->col1->col2->col3->col0).
  - A frame is 4 slots; frame end is the col3 sample.
- Raw code = row_idx*4 + col_idx. Per frame, the classification is NONE, SINGLE(code) or MULTI.
- FSM transitions, evaluated at frame end only:
  - SCAN:
    - SINGLE -> DEBOUNCE with cand=code, cnt=1.
    - NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE equal to cand -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> HELD: key_code<=cand, key_valid=1 for the next cycle only, key_held=1.
    - Any other result -> SCAN, cnt=0.
    - With DEBOUNCE_SCANS=1, acceptance happens on the first frame: go straight from SCAN to HELD.
  - HELD:
    - cand still pressed (other keys pressed as well are ignored) -> stay.
    - cand absent -> RELEASE, cnt=1.
  - RELEASE:
    - cand absent -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> SCAN, key_held=0.
    - cand present -> HELD, cnt=0; no new key_valid.
- Latency: key_valid fires one cycle after the frame-end sample that completes the count, i.e. DEBOUNCE_SCANS frames after the first clean frame.
- Auto-repeat is not provided: no second key_valid until a debounced release has occurred.
- key_err: a MULTI frame sets key_err for the following frame; it never alters key_code.
- reset asserted mid-operation: immediate return to the reset values; no pending key_valid survives.

Optional Feature:
- Macro: KEYPAD_HEXMAP_EN.
- Defined: key_code is taken through the phone-layout hex map.
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
- Undefined: key_code = raw row_idx*4 + col_idx.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - KP_ROWS=4 and KP_COLS=4;
  - the 16-entry hex map constant;
  - the classification enum {NONE, SINGLE, MULTI}.
- Sub-module keypad_col_driver holds the slot prescaler, column ring and sample strobe. It outputs col_out, col_idx, sample_en and frame_end.

Test Plan (CLK_HZ=1000, SCAN_HZ=250, i.e. 4 cycles/slot and 16 cycles/frame; DEBOUNCE_SCANS=2):
- Reset and idle rows=1111:
  - col_out cycles 1110, 1101, 1011, 0111, each for 4 cycles.
  - All outputs stay 0 indefinitely.
- Clean press at row1/col2, held for 5 frames:
  - Exactly one key_valid pulse, 2 frames after the first clean frame.
  - key_code=6 (raw) or 6 (hexmap); key_held=1.
- Press at row3/col0 that bounces (absent in frame 2), then stable:
  - No key_valid until 2 consecutive clean frames.
  - key_code=12 (raw) or 0xE (hexmap).
- Release bounce while held (absent for 1 frame, then present):
  - key_held stays 1; no second key_valid.
  - After 2 absent frames, key_held=0.
- Two keys pressed together (row0/col0 and row2/col3):
  - key_err=1 for the next frame; no key_valid; key_code unchanged.
- reset pulled low during DEBOUNCE:
  - All outputs return to reset values immediately.
  - After release, the press is re-debounced from count 0.
